// File: rtl/reg_probe_scanner.sv
// Register-file debug probe: reads one register through the debug read port and
// presents one OUT_W slice of it with a valid/ready handshake. Manual or auto-scan mode.
// Optional build macro PROBE_TIMESTAMP_EN adds a 16-bit cycle stamp captured with each sample.
module reg_probe_scanner #(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 16,
  parameter int SW       = 1,
  parameter int SCAN_GAP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [AW-1:0]     select,
  input  logic [SW-1:0]     slice_sel,
  output logic [AW-1:0]     rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [OUT_W-1:0]  register_value,
  output logic [AW-1:0]     value_index,
  output logic              value_valid,
`ifdef PROBE_TIMESTAMP_EN
  output logic [15:0]       value_stamp,
`endif
  input  logic              value_ready
);

  localparam int SLICES = DATA_W / OUT_W;
  localparam int GW     = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, GAP} state_t;

  state_t            state;
  state_t            state_next;

  logic [AW-1:0]     scan_idx;
  logic [AW-1:0]     cur_idx;
  logic [SW-1:0]     cur_slice;
  logic              cur_mode;
  logic [GW-1:0]     gap_cnt;

  logic              addr_en;
  logic              data_en;
  logic              accept;
  logic              gap_en;
  logic              gap_done;
  logic              idx_in_range;
  logic [OUT_W-1:0]  slice_data;
  logic [AW-1:0]     req_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scan samples with a zero gap skip the GAP state entirely.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = ADDR;
      ADDR: state_next = DATA;
      DATA: state_next = HOLD;
      HOLD: begin
        if (value_ready) begin
          state_next = (cur_mode && (SCAN_GAP > 0)) ? GAP : ADDR;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_next = ADDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_en  = (state == ADDR);
    data_en  = (state == DATA);
    accept   = (state == HOLD) && value_ready;
    gap_en   = (state == GAP);
    gap_done = (gap_cnt == GW'(SCAN_GAP - 1));
  end

  assign req_idx      = mode ? scan_idx : select;
  assign idx_in_range = (cur_idx != '0) && ({1'b0, cur_idx} < (AW + 1)'(NREGS));

  always_comb begin
    slice_data = '0;
    for (int k = 0; k < SLICES; k++) begin
      if (cur_slice == SW'(k)) begin
        slice_data = rf_rdata[k*OUT_W +: OUT_W];
      end
    end
  end

  // Request side: mode/select/slice_sel are only looked at here.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_raddr  <= '0;
      cur_idx   <= '0;
      cur_slice <= '0;
      cur_mode  <= 1'b0;
    end else if (addr_en) begin
      rf_raddr  <= req_idx;
      cur_idx   <= req_idx;
      cur_slice <= slice_sel;
      cur_mode  <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      register_value <= '0;
      value_index    <= '0;
      value_valid    <= 1'b0;
    end else if (data_en) begin
      register_value <= idx_in_range ? slice_data : '0;
      value_index    <= cur_idx;
      value_valid    <= 1'b1;
    end else if (accept) begin
      value_valid    <= 1'b0;
    end
  end

  // The scan pointer only moves when a scan-mode sample is taken by the observer.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx <= '0;
    end else if (accept && cur_mode) begin
      scan_idx <= (scan_idx == AW'(NREGS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (gap_en) begin
      gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
    end
  end

`ifdef PROBE_TIMESTAMP_EN
  logic [15:0] stamp_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_cnt   <= '0;
      value_stamp <= '0;
    end else begin
      stamp_cnt <= stamp_cnt + 16'd1;
      if (data_en) begin
        value_stamp <= stamp_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_probe_scanner.sv
// Self-checking bench for reg_probe_scanner: a sample-level reference model plus directed
// scenarios for latency, slices, hold stability, scan order/wrap, reset abort and mode resume.
module tb_reg_probe_scanner;

  localparam int NREGS    = 32;
  localparam int AW       = 5;
  localparam int DATA_W   = 32;
  localparam int OUT_W    = 16;
  localparam int SW       = 1;
  localparam int SCAN_GAP = 4;

  logic              clk;
  logic              reset;
  logic              mode;
  logic [AW-1:0]     select;
  logic [SW-1:0]     slice_sel;
  logic [AW-1:0]     rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [OUT_W-1:0]  register_value;
  logic [AW-1:0]     value_index;
  logic              value_valid;
  logic              value_ready;
`ifdef PROBE_TIMESTAMP_EN
  logic [15:0]       value_stamp;
`endif

  logic [DATA_W-1:0] mem [NREGS];

  int checks   = 0;
  int failures = 0;

  reg_probe_scanner #(
    .NREGS(NREGS), .AW(AW), .DATA_W(DATA_W), .OUT_W(OUT_W), .SW(SW), .SCAN_GAP(SCAN_GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .select(select),
    .slice_sel(slice_sel),
    .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata),
    .register_value(register_value),
    .value_index(value_index),
    .value_valid(value_valid),
`ifdef PROBE_TIMESTAMP_EN
    .value_stamp(value_stamp),
`endif
    .value_ready(value_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The register file answers from the registered read address.
  assign rf_rdata = mem[rf_raddr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [AW-1:0] sel,
                               input logic [SW-1:0] sl, input logic rdy);
    mode        = m;
    select      = sel;
    slice_sel   = sl;
    value_ready = rdy;
  endtask

  // Reference model: a new sample reflects the inputs present one edge before valid rises.
  typedef struct packed {
    logic          m;
    logic [AW-1:0] sel;
    logic [SW-1:0] sl;
  } hist_t;

  hist_t       hist_cur;
  hist_t       hist_prev;
  int          exp_scan  = 0;
  int          edges     = 0;
  bit          rst_seen  = 1'b0;
  bit          prev_valid = 1'b0;
  bit          held_mode = 1'b0;
  logic [15:0] held_val;
  logic [AW-1:0] held_idx;
  logic [15:0] held_stamp;

  function automatic logic [15:0] modelValue(input int idx, input int sl);
    logic [31:0] w;
    if (idx == 0 || idx >= NREGS) return 16'h0;
    w = mem[idx];
    return (sl != 0) ? w[31:16] : w[15:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_scan = 0;
      edges    = 0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      edges++;
      if (value_valid && value_ready && held_mode) exp_scan = (exp_scan + 1) % NREGS;
    end
    hist_prev = hist_cur;
    hist_cur  = '{m: mode, sel: select, sl: slice_sel};
  end

  always @(negedge clk) begin
    int idx;
    if (rst_seen) begin
      checkOutput("rst_valid", {31'b0, value_valid}, 32'h0);
      checkOutput("rst_value", {16'b0, register_value}, 32'h0);
      checkOutput("rst_index", {27'b0, value_index}, 32'h0);
    end else if (value_valid && !prev_valid) begin
      idx        = hist_prev.m ? exp_scan : int'(hist_prev.sel);
      held_mode  = hist_prev.m;
      held_idx   = AW'(idx);
      held_val   = modelValue(idx, int'(hist_prev.sl));
      held_stamp = 16'(edges - 1);
      checkOutput("model_index", {27'b0, value_index}, {27'b0, held_idx});
      checkOutput("model_value", {16'b0, register_value}, {16'b0, held_val});
`ifdef PROBE_TIMESTAMP_EN
      checkOutput("model_stamp", {16'b0, value_stamp}, {16'b0, held_stamp});
`endif
    end else if (value_valid && prev_valid) begin
      checkOutput("hold_index", {27'b0, value_index}, {27'b0, held_idx});
      checkOutput("hold_value", {16'b0, register_value}, {16'b0, held_val});
    end
    prev_valid = value_valid;
  end

  // Returns at the negedge where value_valid rises, with the edge count at that point.
  task automatic waitSample(output int cyc);
    bit pv   = value_valid;
    bit seen = 1'b0;
    int n    = 0;
    cyc = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (value_valid && !pv) seen = 1'b1;
      pv = value_valid;
    end
    cyc = edges;
    if (!seen) checkOutput("sample_timeout", 32'h0, 32'h1);
  endtask

  function automatic logic [15:0] scanLiteral(input int i);
    case (i)
      0:       return 16'h0000;
      3:       return 16'h5678;
      5:       return 16'hBEEF;
      default: return 16'(i);
    endcase
  endfunction

  initial begin
    int c0, c1, n;
`ifdef PROBE_TIMESTAMP_EN
    logic [15:0] s0, s1;
`endif
    for (int i = 0; i < NREGS; i++) mem[i] = 32'(i);
    mem[0] = 32'hFFFF_FFFF;
    mem[3] = 32'h1234_5678;
    mem[5] = 32'h0005_BEEF;

    reset = 1'b1;
    applyStimulus(1'b0, 5'd3, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("reset_raddr", {27'b0, rf_raddr}, 32'h0);
    reset = 1'b0;

    // Edge 1 enters ADDR, edge 2 issues the read, edge 3 presents the sample.
    @(negedge clk);
    checkOutput("lat_edge1_valid", {31'b0, value_valid}, 32'h0);
    @(negedge clk);
    checkOutput("lat_edge2_valid", {31'b0, value_valid}, 32'h0);
    checkOutput("lat_edge2_raddr", {27'b0, rf_raddr}, 32'd3);
    @(negedge clk);
    checkOutput("lat_edge3_valid", {31'b0, value_valid}, 32'h1);
    checkOutput("first_value", {16'b0, register_value}, 32'h5678);
    checkOutput("first_index", {27'b0, value_index}, 32'd3);

    applyStimulus(1'b0, 5'd3, 1'b1, 1'b1);
    waitSample(c0);
    waitSample(c1);
    checkOutput("slice1_value", {16'b0, register_value}, 32'h1234);
    checkOutput("manual_period", 32'(c1 - c0), 32'd3);

    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    waitSample(c0);
    waitSample(c0);
    checkOutput("idx0_value", {16'b0, register_value}, 32'h0);
    checkOutput("idx0_index", {27'b0, value_index}, 32'd0);

    applyStimulus(1'b0, 5'd1, 1'b0, 1'b1);
    waitSample(c0);
    waitSample(c0);
    value_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) applyStimulus(1'b0, 5'd5, 1'b0, 1'b0);
    end
    checkOutput("stall_valid", {31'b0, value_valid}, 32'h1);
    checkOutput("stall_index", {27'b0, value_index}, 32'd1);
    checkOutput("stall_value", {16'b0, register_value}, 32'h1);
    value_ready = 1'b1;
    waitSample(c0);
    checkOutput("after_stall_index", {27'b0, value_index}, 32'd5);
    checkOutput("after_stall_value", {16'b0, register_value}, 32'hBEEF);

    applyStimulus(1'b1, 5'd5, 1'b0, 1'b1);
    c0 = 0;
    for (int i = 0; i < 33; i++) begin
      waitSample(c1);
      checkOutput("scan_index", {27'b0, value_index}, 32'(i % NREGS));
      checkOutput("scan_value", {16'b0, register_value}, {16'b0, scanLiteral(i % NREGS)});
      if (i > 0) checkOutput("scan_period", 32'(c1 - c0), 32'(3 + SCAN_GAP));
      c0 = c1;
    end

    n = 0;
    while (value_index != 5'd17 && n < 40) begin
      waitSample(c1);
      n++;
    end
    checkOutput("reach_idx17", {27'b0, value_index}, 32'd17);
    value_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_valid", {31'b0, value_valid}, 32'h0);
    checkOutput("abort_value", {16'b0, register_value}, 32'h0);
    reset       = 1'b0;
    value_ready = 1'b1;
    waitSample(c1);
    checkOutput("restart_index", {27'b0, value_index}, 32'd0);

    applyStimulus(1'b0, 5'd7, 1'b0, 1'b1);
    repeat (3) waitSample(c1);
    checkOutput("manual7_index", {27'b0, value_index}, 32'd7);
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b1);
    n = 0;
    do begin
      waitSample(c1);
      n++;
    end while (value_index == 5'd7 && n < 5);
    checkOutput("resume_index", {27'b0, value_index}, 32'd1);
    checkOutput("resume_value", {16'b0, register_value}, 32'h1);

`ifdef PROBE_TIMESTAMP_EN
    applyStimulus(1'b0, 5'd3, 1'b0, 1'b1);
    waitSample(c0);
    waitSample(c0);
    s0 = value_stamp;
    waitSample(c1);
    s1 = value_stamp;
    checkOutput("stamp_delta", {16'b0, 16'(s1 - s0)}, 32'd3);
    repeat (70000) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/reg_probe_scanner.md
Name: reg_probe_scanner

Overview:
- Parametrised debug probe that reads CPU register-file contents through a dedicated read port and presents them one slice at a time on `register_value`.
- Successor to the fixed 5-bit-select / 16-bit-value debug tap. Adds:
  - configurable register count and data/output widths;
  - slice selection;
  - an auto-scan mode;
  - a valid/ready output handshake.
- Sits between the core's register-file debug read port and the board/bench observer.

Parameters:
- NREGS, 32, number of architectural registers; index 0 always reads as zero.
- AW, 5, register index width; NREGS <= 2**AW.
- DATA_W, 32, register width.
- OUT_W, 16, output slice width; DATA_W must be a multiple of OUT_W; SLICES = DATA_W/OUT_W >= 2.
- SW, 1, slice-select width = clog2(SLICES).
- SCAN_GAP, 4, idle cycles between accepted samples in scan mode (0 allowed).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = manual (use `select`), 1 = auto-scan.
- select  in  AW  register index in manual mode.
- slice_sel  in  SW  output slice; slice k = bits [k*OUT_W +: OUT_W].
- rf_raddr  out  AW  register-file debug read address.
- rf_rdata  in  DATA_W  register-file read data, valid exactly 1 cycle after rf_raddr.
- register_value  out  OUT_W  captured slice.
- value_index  out  AW  register index of the held sample.
- value_valid  out  1  sample held and available.
- value_ready  in  1  observer accepts the sample.

Behaviour:
- One clock; reset is synchronous and active-high. On reset:
  - register_value = 0, value_index = 0, value_valid = 0, rf_raddr = 0;
  - scan index = 0, gap counter = 0;
  - FSM to IDLE.
  - Reset asserted mid-operation aborts any held or in-flight sample on the next edge.
- FSM states: IDLE, ADDR, DATA, HOLD, GAP.
- IDLE → ADDR unconditionally (1 cycle).
- ADDR:
  - rf_raddr <= (mode ? scan_idx : select);
  - latch that index and slice_sel into cur_idx / cur_slice;
  - → DATA.
- DATA:
  - register_value <= (cur_idx == 0) ? 0 : rf_rdata slice cur_slice;
  - value_index <= cur_idx; value_valid <= 1; → HOLD.
- Latency: a request issued in ADDR appears on the outputs 2 edges later.
- HOLD:
  - value_valid stays 1; register_value and value_index stay stable until value_ready is sampled high.
  - On the accept edge: value_valid <= 0.
  - Next state: scan mode → GAP; manual mode → ADDR.
  - In scan mode, scan_idx advances on the accept edge: scan_idx <= (scan_idx == NREGS-1) ? 0 : scan_idx+1.
- GAP:
  - Counts SCAN_GAP cycles, then → ADDR.
  - SCAN_GAP = 0 → straight to ADDR the cycle after accept.
- If value_ready is already high when value_valid rises, the sample is accepted on the first HOLD edge; no extra cycle is added.
- mode, select and slice_sel changes are sampled only in ADDR.
  - A change during DATA/HOLD/GAP affects the next sample only; the held sample is never modified.
- Switching mode 1 → 0 leaves scan_idx unchanged. Scan resumes from that index when mode returns to 1.
- select >= NREGS in manual mode: read is issued, register_value forced to 0, value_index reports the select value.
- Manual throughput: one sample per 3 cycles with value_ready held high (ADDR, DATA, HOLD).

Optional Feature:
- Macro: PROBE_TIMESTAMP_EN.
- Defined:
  - adds output `value_stamp` (16 bits), fed by a free-running 16-bit cycle counter;
  - the counter resets to 0, increments every cycle and wraps 0xFFFF → 0;
  - value_stamp captures the counter value in the DATA cycle and is held with the sample;
  - value_stamp resets to 0.
- Undefined: port, counter and capture register are absent; all other behaviour is identical.

Test Plan:
- Reset held 10 cycles, then released with mode=0, select=3, slice_sel=0, rf returns 0x12345678 at addr 3, value_ready=1 → value_valid first high 2 edges after ADDR, register_value=0x5678, value_index=3.
- Same setup with slice_sel=1 → register_value=0x1234. Then select=0 with rf returning 0xFFFFFFFF → register_value=0x0000.
- value_ready=0 for 20 cycles with a sample held; change select 1→5 mid-hold → register_value/value_index unchanged and valid stays 1; after value_ready=1, the next sample shows index 5.
- mode=1, NREGS=32, SCAN_GAP=4, value_ready=1, rf_rdata=addr → indices 0,1,…,31,0 in order; successive valid rises 7 cycles apart; wrap 31→0 verified.
- Reset asserted for 1 cycle while in HOLD at index 17 (scan) → next edge: value_valid=0, register_value=0; the scan restarts at index 0.
- PROBE_TIMESTAMP_EN defined, manual mode, value_ready=1 → value_stamp differs by 3 between consecutive samples. Run 70000 cycles to check the counter wrap.
